branch_predictor: RTL and testbench

Dynamic branch direction predictor for the five-stage pipeline. A table of 2-bit saturating counters is indexed by low PC bits. It produces a same-cycle taken/not-taken prediction for the branch currently in ID. That prediction travels down the pipeline to the EX-stage branch check, which resolves the branch and triggers any flush. The resolved outcome is fed back here to train the table, and the block also keeps branch and mispredict statistics.

---
 rtl/branch_predictor_if.sv | 32 +++
 rtl/branch_predictor.sv | 70 +++++++
 tb/tb_branch_predictor.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
// branch_predictor_if
// Lookup/update/statistics bundle between the pipeline and branch_predictor.
// Revision: 1.0
// ============================================================================
interface branch_predictor_if #(
  parameter int CNT_W = 16
);
  logic             lookup_valid_i;
  logic [31:0]      lookup_pc_i;
  logic             predict_o;
  logic             update_valid_i;
  logic [31:0]      update_pc_i;
  logic             update_taken_i;
  logic             update_predict_i;
  logic [CNT_W-1:0] branch_cnt_o;
  logic [CNT_W-1:0] mispredict_cnt_o;

  modport master (
    output lookup_valid_i, lookup_pc_i,
    output update_valid_i, update_pc_i, update_taken_i, update_predict_i,
    input  predict_o, branch_cnt_o, mispredict_cnt_o
  );

  modport slave (
    input  lookup_valid_i, lookup_pc_i,
    input  update_valid_i, update_pc_i, update_taken_i, update_predict_i,
    output predict_o, branch_cnt_o, mispredict_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// branch_predictor
// Untagged table of 2-bit saturating counters with branch/mispredict stats.
// Revision: 1.0
// ============================================================================
module branch_predictor #(
  parameter int         INDEX_W    = 2,
  parameter logic [1:0] INIT_STATE = 2'b11,
  parameter int         CNT_W      = 16
) (
  input  wire logic          clk_i,
  input  wire logic          rst_i,
  branch_predictor_if.slave  bp
);
  localparam int ENTRIES = 2 ** INDEX_W;

  logic [1:0]         pht [ENTRIES];
  logic [INDEX_W-1:0] lookup_idx;
  logic [INDEX_W-1:0] update_idx;
  logic [1:0]         cur_state;
  logic [1:0]         next_state;
  logic [CNT_W-1:0]   branch_cnt;
  logic [CNT_W-1:0]   mispredict_cnt;
  logic               unused_pc_bits;

  assign lookup_idx = bp.lookup_pc_i[INDEX_W+1:2];
  assign update_idx = bp.update_pc_i[INDEX_W+1:2];
  assign unused_pc_bits = ^{bp.lookup_pc_i[31:INDEX_W+2], bp.lookup_pc_i[1:0],
                            bp.update_pc_i[31:INDEX_W+2], bp.update_pc_i[1:0]};

  // No write bypass: a same-cycle update to this index shows up next cycle.
  assign bp.predict_o = bp.lookup_valid_i & pht[lookup_idx][1];

  always_comb begin
    cur_state  = pht[update_idx];
    next_state = cur_state;
    if (bp.update_taken_i) begin
      if (cur_state != 2'b11) next_state = cur_state + 2'd1;
    end else begin
      if (cur_state != 2'b00) next_state = cur_state - 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) pht[i] <= INIT_STATE;
    end else if (bp.update_valid_i) begin
      pht[update_idx] <= next_state;
    end
  end

  // Mispredicts come only from the prediction carried down the pipeline.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (bp.update_valid_i) begin
      if (branch_cnt != {CNT_W{1'b1}})
        branch_cnt <= branch_cnt + 1'b1;
      if ((bp.update_taken_i != bp.update_predict_i) &&
          (mispredict_cnt != {CNT_W{1'b1}}))
        mispredict_cnt <= mispredict_cnt + 1'b1;
    end
  end

  assign bp.branch_cnt_o     = branch_cnt;
  assign bp.mispredict_cnt_o = mispredict_cnt;
endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// tb_branch_predictor
// Directed checks of prediction, training, aliasing, hazards, stats, reset.
// Revision: 1.0
// ============================================================================
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  branch_predictor_if #(.CNT_W(4)) bus ();

  branch_predictor #(
    .INDEX_W   (2),
    .INIT_STATE(2'b11),
    .CNT_W     (4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bp   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic lookup(input logic [31:0] pc);
    bus.lookup_valid_i = 1'b1;
    bus.lookup_pc_i    = pc;
    #1;
  endtask

  // One training edge; inputs settle mid-cycle and drop just after the edge.
  task automatic update(input logic [31:0] pc, input logic taken, input logic pred);
    bus.update_valid_i   = 1'b1;
    bus.update_pc_i      = pc;
    bus.update_taken_i   = taken;
    bus.update_predict_i = pred;
    @(posedge clk);
    #1;
    bus.update_valid_i   = 1'b0;
  endtask

  initial begin
    bus.lookup_valid_i   = 1'b0;
    bus.lookup_pc_i      = '0;
    bus.update_valid_i   = 1'b0;
    bus.update_pc_i      = '0;
    bus.update_taken_i   = 1'b0;
    bus.update_predict_i = 1'b0;

    // Reset defaults
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    lookup(32'h10);
    check("reset_predict", 16'(bus.predict_o), 16'd1);
    check("reset_branch_cnt", 16'(bus.branch_cnt_o), 16'd0);
    check("reset_mispredict_cnt", 16'(bus.mispredict_cnt_o), 16'd0);
    bus.lookup_valid_i = 1'b0;
    #1;
    check("invalid_lookup", 16'(bus.predict_o), 16'd0);

    // Training walk on index 2
    update(32'h08, 1'b0, 1'b1); lookup(32'h08);
    check("walk_nt1_10", 16'(bus.predict_o), 16'd1);
    update(32'h08, 1'b0, 1'b1); lookup(32'h08);
    check("walk_nt2_01", 16'(bus.predict_o), 16'd0);
    update(32'h08, 1'b0, 1'b0); lookup(32'h08);
    check("walk_nt3_00", 16'(bus.predict_o), 16'd0);
    update(32'h08, 1'b0, 1'b0); lookup(32'h08);
    check("walk_nt4_sat00", 16'(bus.predict_o), 16'd0);
    update(32'h08, 1'b1, 1'b0); lookup(32'h08);
    check("walk_t1_01", 16'(bus.predict_o), 16'd0);
    update(32'h08, 1'b1, 1'b0); lookup(32'h08);
    check("walk_t2_10", 16'(bus.predict_o), 16'd1);
    check("walk_branch_cnt", 16'(bus.branch_cnt_o), 16'd6);
    check("walk_mispredict_cnt", 16'(bus.mispredict_cnt_o), 16'd4);

    // Aliasing: 0x04 and 0x14 share index 1, index 2 untouched
    update(32'h04, 1'b0, 1'b1);
    update(32'h04, 1'b0, 1'b1);
    lookup(32'h04);
    check("alias_pc04", 16'(bus.predict_o), 16'd0);
    lookup(32'h14);
    check("alias_pc14", 16'(bus.predict_o), 16'd0);
    lookup(32'h08);
    check("isolate_pc08", 16'(bus.predict_o), 16'd1);
    lookup(32'h00);
    check("isolate_pc00", 16'(bus.predict_o), 16'd1);

    // Same-cycle lookup/update to index 3: entry 3 first brought to 10
    update(32'h0C, 1'b0, 1'b1);
    lookup(32'h0C);
    bus.update_valid_i   = 1'b1;
    bus.update_pc_i      = 32'h0C;
    bus.update_taken_i   = 1'b0;
    bus.update_predict_i = 1'b1;
    #1;
    check("hazard_same_cycle", 16'(bus.predict_o), 16'd1);
    @(posedge clk);
    #1;
    bus.update_valid_i = 1'b0;
    #1;
    check("hazard_next_cycle", 16'(bus.predict_o), 16'd0);
    check("hazard_branch_cnt", 16'(bus.branch_cnt_o), 16'd10);
    check("hazard_mispredict_cnt", 16'(bus.mispredict_cnt_o), 16'd8);

    // Async reset between edges, with an update held during reset
    @(posedge clk);
    #2;
    bus.update_valid_i   = 1'b1;
    bus.update_pc_i      = 32'h08;
    bus.update_taken_i   = 1'b0;
    bus.update_predict_i = 1'b1;
    rst = 1'b1;
    #1;
    check("async_branch_cnt", 16'(bus.branch_cnt_o), 16'd0);
    check("async_mispredict_cnt", 16'(bus.mispredict_cnt_o), 16'd0);
    lookup(32'h04);
    check("async_pc04", 16'(bus.predict_o), 16'd1);
    lookup(32'h0C);
    check("async_pc0C", 16'(bus.predict_o), 16'd1);
    @(posedge clk);
    #1;
    lookup(32'h08);
    check("reset_update_dropped", 16'(bus.predict_o), 16'd1);
    check("reset_update_no_count", 16'(bus.branch_cnt_o), 16'd0);
    bus.update_valid_i = 1'b0;
    rst = 1'b0;
    #1;

    // Statistics saturation at 15 with alternating mispredicts
    for (int i = 0; i < 20; i++) begin
      update(32'h10, 1'b1, (i % 2 == 0) ? 1'b0 : 1'b1);
      if (i == 14) check("stats_branch_reach15", 16'(bus.branch_cnt_o), 16'd15);
      if (i == 15) check("stats_branch_hold15", 16'(bus.branch_cnt_o), 16'd15);
    end
    check("stats_branch_sat", 16'(bus.branch_cnt_o), 16'd15);
    check("stats_mispredict", 16'(bus.mispredict_cnt_o), 16'd10);
    lookup(32'h10);
    check("stats_entry0_sat11", 16'(bus.predict_o), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
